// File: rtl/banked_mem.sv
// Four-bank word-interleaved 16-bit memory with per-bank occupancy counters.
// Requests to a free bank are accepted at once; reads return data two cycles later.
module banked_mem #(
    parameter int ADDR_W      = 16,
    parameter int WORDS_LOG2  = 13,
    parameter int BANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [15:0]       data_out,
    output logic [3:0]        busy,
    output logic              stall,
    output logic              err
);

    localparam int DATA_W = 16;

    logic [DATA_W-1:0]     mem [2**WORDS_LOG2];
    logic [2:0]            cnt [4];
    logic [WORDS_LOG2-1:0] word;
    logic [1:0]            bank;
    logic                  req;
    logic                  illegal;
    logic                  legal;
    logic                  accept;
    logic [DATA_W-1:0]     rdata_p1;
    logic                  vld_p1;
    logic                  unused_addr_hi;

    // Upper address bits alias onto the stored words.
    assign unused_addr_hi = ^addr[ADDR_W-1:WORDS_LOG2+1];

    assign word    = addr[WORDS_LOG2:1];
    assign bank    = addr[2:1];
    assign req     = rd | wr;
    assign illegal = req & ((rd & wr) | addr[0]);
    assign legal   = req & ~illegal;
    assign stall   = legal & busy[bank];
    assign accept  = legal & ~busy[bank];

    always_comb begin
        busy = '0;
        for (int i = 0; i < 4; i++) begin
            busy[i] = (cnt[i] != 3'd0);
        end
    end

    // Stage 0 -> 1: array write and read capture on the accepting edge.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[word] <= data_in;
        end
        if (accept && rd) begin
            rdata_p1 <= mem[word];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 3'd0;
            end
            vld_p1   <= 1'b0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && bank == 2'(i)) begin
                    cnt[i] <= 3'(BANK_CYCLES);
                end else if (cnt[i] != 3'd0) begin
                    cnt[i] <= cnt[i] - 3'd1;
                end
            end
            vld_p1 <= accept & rd;
            // Stage 1 -> 2: data_out holds until the next read result.
            if (vld_p1) begin
                data_out <= rdata_p1;
            end
            err <= illegal;
        end
    end

endmodule

// File: tb/tb_banked_mem.sv
// Directed vector bench for banked_mem: per-cycle table plus reset sequences.
module tb_banked_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_out;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        stall;
        logic        err;
        logic [3:0]  busy;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[$];

    banked_mem #(.ADDR_W(16), .WORDS_LOG2(13), .BANK_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .busy(busy), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic s, input logic e, input logic [3:0] b, input logic [15:0] o);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.din = d;
        v.stall = s; v.err = e; v.busy = b; v.dout = o;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic [3:0] b, input logic [15:0] o);
        add(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, b, o);
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rd = r; wr = w; addr = a; data_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // round trip on bank 0
        add(0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 16'h0000);
        repeat (4) idle(4'b0001, 16'h0000);
        add(1, 0, 16'h0010, 16'h0, 0, 0, 4'b0000, 16'h0000);
        idle(4'b0001, 16'h0000);
        repeat (3) idle(4'b0001, 16'hBEEF);
        // preload the interleaved line
        add(0, 1, 16'h0040, 16'h1111, 0, 0, 4'b0000, 16'hBEEF);
        add(0, 1, 16'h0042, 16'h2222, 0, 0, 4'b0001, 16'hBEEF);
        add(0, 1, 16'h0044, 16'h3333, 0, 0, 4'b0011, 16'hBEEF);
        add(0, 1, 16'h0046, 16'h4444, 0, 0, 4'b0111, 16'hBEEF);
        idle(4'b1111, 16'hBEEF);
        idle(4'b1110, 16'hBEEF);
        idle(4'b1100, 16'hBEEF);
        idle(4'b1000, 16'hBEEF);
        idle(4'b0000, 16'hBEEF);
        // interleaved fill, back-to-back reads
        add(1, 0, 16'h0040, 16'h0, 0, 0, 4'b0000, 16'hBEEF);
        add(1, 0, 16'h0042, 16'h0, 0, 0, 4'b0001, 16'hBEEF);
        add(1, 0, 16'h0044, 16'h0, 0, 0, 4'b0011, 16'h1111);
        add(1, 0, 16'h0046, 16'h0, 0, 0, 4'b0111, 16'h2222);
        idle(4'b1111, 16'h3333);
        idle(4'b1110, 16'h4444);
        idle(4'b1100, 16'h4444);
        idle(4'b1000, 16'h4444);
        // aliased write lands on word 0
        add(0, 1, 16'h4000, 16'h5A5A, 0, 0, 4'b0000, 16'h4444);
        repeat (4) idle(4'b0001, 16'h4444);
        // bank conflict: held read stalls four cycles
        add(0, 1, 16'h0008, 16'hA5A5, 0, 0, 4'b0000, 16'h4444);
        repeat (4) add(1, 0, 16'h0000, 16'h0, 1, 0, 4'b0001, 16'h4444);
        add(1, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 16'h4444);
        idle(4'b0001, 16'h4444);
        repeat (3) idle(4'b0001, 16'h5A5A);
        // illegal requests
        add(1, 0, 16'h0003, 16'h0, 0, 0, 4'b0000, 16'h5A5A);
        add(0, 0, 16'h0000, 16'h0, 0, 1, 4'b0000, 16'h5A5A);
        add(1, 1, 16'h0006, 16'hDEAD, 0, 0, 4'b0000, 16'h5A5A);
        add(0, 0, 16'h0000, 16'h0, 0, 1, 4'b0000, 16'h5A5A);
        add(0, 1, 16'h0002, 16'h1234, 0, 0, 4'b0000, 16'h5A5A);
        add(1, 0, 16'h0003, 16'h0, 0, 0, 4'b0010, 16'h5A5A);
        add(0, 0, 16'h0000, 16'h0, 0, 1, 4'b0010, 16'h5A5A);
        idle(4'b0010, 16'h5A5A);
        idle(4'b0010, 16'h5A5A);
        add(1, 0, 16'h0002, 16'h0, 0, 0, 4'b0000, 16'h5A5A);
        idle(4'b0010, 16'h5A5A);
        idle(4'b0010, 16'h1234);
        add(0, 1, 16'h0011, 16'hFFFF, 0, 0, 4'b0010, 16'h1234);
        add(0, 0, 16'h0000, 16'h0, 0, 1, 4'b0010, 16'h1234);
        add(1, 0, 16'h0010, 16'h0, 0, 0, 4'b0000, 16'h1234);
        idle(4'b0001, 16'h1234);
        idle(4'b0001, 16'hBEEF);
        idle(4'b0001, 16'hBEEF);

        // asynchronous reset at start, checked before any clock edge
        #1 rst = 1'b0;
        #2;
        check("rst0 data_out", data_out, 16'h0000);
        check("rst0 busy", 16'(busy), 16'h0000);
        check("rst0 err", 16'(err), 16'h0000);
        check("rst0 stall", 16'(stall), 16'h0000);
        @(posedge clk);
        #3 rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
            #3;
            check($sformatf("v%0d stall", i), 16'(stall), 16'(vecs[i].stall));
            check($sformatf("v%0d err", i), 16'(err), 16'(vecs[i].err));
            check($sformatf("v%0d busy", i), 16'(busy), 16'(vecs[i].busy));
            check($sformatf("v%0d data_out", i), data_out, vecs[i].dout);
            step();
        end

        // write survives reset; accepted read is dropped by a reset in T+1
        drive(0, 1, 16'h0022, 16'h7777);
        step();
        drive(0, 0, 16'h0, 16'h0);
        repeat (4) step();
        drive(1, 0, 16'h0022, 16'h0);
        #3 check("midrd accept stall", 16'(stall), 16'h0000);
        step();
        drive(0, 0, 16'h0, 16'h0);
        rst = 1'b0;
        #1;
        check("midrd rst data_out", data_out, 16'h0000);
        check("midrd rst busy", 16'(busy), 16'h0000);
        @(posedge clk);
        #3 rst = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            #3;
            check($sformatf("post-rst%0d data_out", k), data_out, 16'h0000);
            check($sformatf("post-rst%0d busy", k), 16'(busy), 16'h0000);
            step();
        end
        drive(1, 0, 16'h0022, 16'h0);
        step();
        drive(0, 0, 16'h0, 16'h0);
        step();
        #3 check("prerst write readback", data_out, 16'h7777);
        step();

        // reset clears a pending err pulse immediately
        drive(1, 0, 16'h0001, 16'h0);
        step();
        drive(0, 0, 16'h0, 16'h0);
        #3 check("err before rst", 16'(err), 16'h0001);
        rst = 1'b0;
        #1;
        check("err cleared by rst", 16'(err), 16'h0000);
        check("data_out cleared by rst", data_out, 16'h0000);
        @(posedge clk);
        #3 rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
